// File: rtl/data_fifo.sv
// Synchronous single-clock FIFO with wrap-bit pointers, occupancy/threshold
// flags, sticky overflow/underflow errors and optional first-word-fall-through.
module data_fifo #(
  parameter int DataWidth = 64,
  parameter int Depth     = 8,
  parameter int Fwft      = 0,
  parameter int AFullThr  = Depth - 1,
  parameter int AEmptyThr = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Flush,
  input  logic [DataWidth-1:0]   WData,
  input  logic                   WInc,
  output logic                   WFull,
  output logic [DataWidth-1:0]   RData,
  input  logic                   RInc,
  output logic                   REmpty,
  output logic [$clog2(Depth):0] Count,
  output logic                   AlmostFull,
  output logic                   AlmostEmpty,
  output logic                   OverflowErr,
  output logic                   UnderflowErr
);

  localparam int AW = $clog2(Depth);

  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic [DataWidth-1:0] mem [Depth];
  logic                 w_acc;
  logic                 r_acc;
  logic [31:0]          count_ext;

  // Full when the addresses match but the wrap bits differ.
  assign WFull  = (wptr == {~rptr[AW], rptr[AW-1:0]});
  assign REmpty = (wptr == rptr);
  assign Count  = wptr - rptr;

  assign count_ext   = {{(31 - AW){1'b0}}, Count};
  assign AlmostFull  = $signed(count_ext) >= AFullThr;
  assign AlmostEmpty = $signed(count_ext) <= AEmptyThr;

  assign w_acc = WInc && !WFull;
  assign r_acc = RInc && !REmpty;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wptr         <= '0;
      rptr         <= '0;
      OverflowErr  <= 1'b0;
      UnderflowErr <= 1'b0;
    end else if (Flush) begin
      wptr         <= '0;
      rptr         <= '0;
      OverflowErr  <= 1'b0;
      UnderflowErr <= 1'b0;
    end else begin
      if (w_acc) wptr <= wptr + (AW + 1)'(1);
      if (r_acc) rptr <= rptr + (AW + 1)'(1);
      if (WInc && WFull)  OverflowErr  <= 1'b1;
      if (RInc && REmpty) UnderflowErr <= 1'b1;
    end
  end

  // NOTE: storage has no reset; cleared pointers make stale entries unreachable,
  // and leaving it out lets the array map onto plain RAM.
  always_ff @(posedge Clk) begin
    if (w_acc && !Flush) mem[wptr[AW-1:0]] <= WData;
  end

  generate
    if (Fwft != 0) begin : g_fwft
      assign RData = mem[rptr[AW-1:0]];
    end else begin : g_reg
      logic [DataWidth-1:0] rdata_q;

      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)       rdata_q <= '0;
        else if (Flush) rdata_q <= '0;
        else if (r_acc) rdata_q <= mem[rptr[AW-1:0]];
      end

      assign RData = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_data_fifo.sv
// Bench for data_fifo: directed fill/drain/wrap/flush/reset steps plus a random
// stream, all scored against a queue-based model of the FIFO's behaviour.
module tb_data_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;
  localparam int AET   = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, winc, rinc;
  logic [DW-1:0] wdata;
  logic          wfull, rempty, afull, aempty, ovf, unf;
  logic [DW-1:0] rdata;
  logic [2:0]    count;

  logic          f_flush, f_winc, f_rinc;
  logic [DW-1:0] f_wdata;
  logic          f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_unf;
  logic [DW-1:0] f_rdata;
  logic [2:0]    f_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  data_fifo #(.DataWidth(DW), .Depth(DEPTH), .Fwft(0), .AFullThr(AFT), .AEmptyThr(AET)) dut (
    .Clk(clk), .Rst(rst), .Flush(flush), .WData(wdata), .WInc(winc), .WFull(wfull),
    .RData(rdata), .RInc(rinc), .REmpty(rempty), .Count(count), .AlmostFull(afull),
    .AlmostEmpty(aempty), .OverflowErr(ovf), .UnderflowErr(unf)
  );

  data_fifo #(.DataWidth(DW), .Depth(DEPTH), .Fwft(1), .AFullThr(AFT), .AEmptyThr(AET)) dut_fwft (
    .Clk(clk), .Rst(rst), .Flush(f_flush), .WData(f_wdata), .WInc(f_winc), .WFull(f_wfull),
    .RData(f_rdata), .RInc(f_rinc), .REmpty(f_rempty), .Count(f_count), .AlmostFull(f_afull),
    .AlmostEmpty(f_aempty), .OverflowErr(f_ovf), .UnderflowErr(f_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    check({ctx, ".count"},  32'(count),  32'(n));
    check({ctx, ".wfull"},  32'(wfull),  32'(n == DEPTH));
    check({ctx, ".rempty"}, 32'(rempty), 32'(n == 0));
    check({ctx, ".afull"},  32'(afull),  32'(n >= AFT));
    check({ctx, ".aempty"}, 32'(aempty), 32'(n <= AET));
    check({ctx, ".ovf"},    32'(ovf),    32'(m_ovf));
    check({ctx, ".unf"},    32'(unf),    32'(m_unf));
    check({ctx, ".rdata"},  32'(rdata),  32'(m_rdata));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_rdata = '0;
  endtask

  // One clock of the registered-read FIFO: drive, advance the model, then score.
  task automatic step(input string ctx, input logic w, input logic r,
                      input logic [7:0] d, input logic fl);
    bit was_full, was_empty;
    @(negedge clk);
    winc  = w;
    rinc  = r;
    wdata = d;
    flush = fl;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (fl) begin
      model_reset();
    end else begin
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      if (r && !was_empty) m_rdata = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic f_step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    f_winc  = w;
    f_rinc  = r;
    f_wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    f_flush = 1'b0; f_winc = 1'b0; f_rinc = 1'b0; f_wdata = '0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fill, then overflow attempt.
    step("fill0", 1, 0, 8'h11, 0);
    step("fill1", 1, 0, 8'h22, 0);
    step("fill2", 1, 0, 8'h33, 0);
    check("fill2.afull_at3", 32'(afull), 32'd1);
    step("fill3", 1, 0, 8'h44, 0);
    step("fill_over", 1, 0, 8'h55, 0);
    check("over.count_stays4", 32'(count), 32'd4);

    // Drain, then underflow attempt.
    step("drain0", 0, 1, 8'h00, 0);
    check("drain0.first", 32'(rdata), 32'h11);
    step("drain1", 0, 1, 8'h00, 0);
    step("drain2", 0, 1, 8'h00, 0);
    step("drain3", 0, 1, 8'h00, 0);
    step("drain_under", 0, 1, 8'h00, 0);
    check("under.rdata_held", 32'(rdata), 32'h44);

    // Simultaneous requests at full and at empty.
    step("clr0", 0, 0, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) step("refill", 1, 0, 8'(8'hA0 + i), 0);
    step("sim_full", 1, 1, 8'hEE, 0);
    check("sim_full.count3", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step("redrain", 0, 1, 8'h00, 0);
    step("sim_empty", 1, 1, 8'hC7, 0);
    check("sim_empty.count1", 32'(count), 32'd1);
    check("sim_empty.rdata_held", 32'(rdata), 32'hA3);

    // Streaming across pointer wrap with occupancy held at two.
    step("clr1", 0, 0, 8'h00, 1);
    step("wrap_w0", 1, 0, 8'h00, 0);
    step("wrap_w1", 1, 0, 8'h01, 0);
    for (int i = 2; i < 10; i++) step("wrap_wr", 1, 1, 8'(i), 0);
    step("wrap_r8", 0, 1, 8'h00, 0);
    step("wrap_r9", 0, 1, 8'h00, 0);
    check("wrap.last", 32'(rdata), 32'h09);

    // Flush beats a write and clears a raised error flag.
    for (int i = 0; i < DEPTH; i++) step("pre_flush", 1, 0, 8'(8'h60 + i), 0);
    step("pre_flush_over", 1, 0, 8'h6F, 0);
    step("pre_flush_rd", 0, 1, 8'h00, 0);
    check("pre_flush.ovf", 32'(ovf), 32'd1);
    step("flush_w", 1, 0, 8'h77, 1);
    check("flush.count0", 32'(count), 32'd0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 31) == 0));

    // Asynchronous reset between clock edges, mid-stream.
    step("pre_rst", 1, 0, 8'h5A, 0);
    @(negedge clk);
    winc = 1'b1; rinc = 1'b0; wdata = 8'hF0; flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    winc = 1'b0;
    #1;
    check_all("rst_release");
    step("post_rst_w0", 1, 0, 8'h3C, 0);
    step("post_rst_w1", 1, 0, 8'h3D, 0);
    step("post_rst_r0", 0, 1, 8'h00, 0);
    check("post_rst.first", 32'(rdata), 32'h3C);
    step("idle", 0, 0, 8'h00, 0);

    // First-word-fall-through instance.
    f_step(0, 0, 8'h00);
    check("fwft.empty0", 32'(f_rempty), 32'd1);
    f_step(1, 0, 8'hA5);
    check("fwft.nonempty", 32'(f_rempty), 32'd0);
    check("fwft.rdata_a5", 32'(f_rdata), 32'hA5);
    f_step(1, 0, 8'h5A);
    check("fwft.head_held", 32'(f_rdata), 32'hA5);
    f_step(0, 1, 8'h00);
    check("fwft.next_5a", 32'(f_rdata), 32'h5A);
    f_step(0, 1, 8'h00);
    check("fwft.empty_after", 32'(f_rempty), 32'd1);
    check("fwft.no_unf", 32'(f_unf), 32'd0);
    f_step(0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_fifo.md
DATA_FIFO -- requirements
Module: data_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 64, width of each stored word.
REQ-002 SHALL have parameter Depth, default 8, number of entries; power of two, >= 2.
REQ-003 SHALL have parameter Fwft, default 0: 0 = registered read data; 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFullThr, default Depth-1, almost-full threshold in entries.
REQ-005 SHALL have parameter AEmptyThr, default 1, almost-empty threshold in entries.
REQ-006 SHALL have port Clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port Flush, input, 1, synchronous clear of all contents.
REQ-009 SHALL have port WData, input, DataWidth, write data.
REQ-010 SHALL have port WInc, input, 1, write request.
REQ-011 SHALL have port WFull, output, 1, FIFO holds Depth entries.
REQ-012 SHALL have port RData, output, DataWidth, read data.
REQ-013 SHALL have port RInc, input, 1, read request.
REQ-014 SHALL have port REmpty, output, 1, FIFO holds 0 entries.
REQ-015 SHALL have port Count, output, log2(Depth)+1, current occupancy 0..Depth.
REQ-016 SHALL have port AlmostFull, output, 1, Count >= AFullThr.
REQ-017 SHALL have port AlmostEmpty, output, 1, Count <= AEmptyThr.
REQ-018 SHALL have port OverflowErr, output, 1, sticky flag: write attempted while full.
REQ-019 SHALL have port UnderflowErr, output, 1, sticky flag: read attempted while empty.

Function
REQ-020 SHALL keep write and read pointers of log2(Depth)+1 bits; low bits address storage, MSB is the wrap bit; both wrap modulo 2*Depth.
REQ-021 SHALL derive WFull, REmpty, Count (= wptr - rptr, modulo width), AlmostFull and AlmostEmpty combinationally from registered pointers only, never from same-cycle requests.
REQ-022 SHALL accept a write iff WInc=1 and WFull=0: store WData at the write address and advance wptr by 1; storage is not modified by a rejected write.
REQ-023 SHALL accept a read iff RInc=1 and REmpty=0: advance rptr by 1.
REQ-024 SHALL, when full with WInc=RInc=1, reject the write and accept the read (Count becomes Depth-1).
REQ-025 SHALL, when empty with WInc=RInc=1, reject the read and accept the write (no bypass; Count becomes 1).
REQ-026 SHALL, with 0 < Count < Depth and WInc=RInc=1, accept both; Count unchanged.
REQ-027 SHALL (Fwft=0) register RData one cycle after an accepted read with the entry at the pre-increment rptr, and hold RData unchanged on all other cycles, including rejected reads.
REQ-028 SHALL (Fwft=1) drive RData with the entry at rptr whenever REmpty=0; a written word appears on RData the cycle after its write into an empty FIFO; RData is don't-care while REmpty=1.
REQ-029 SHALL set OverflowErr on any cycle with WInc=1 and WFull=1, and UnderflowErr on any cycle with RInc=1 and REmpty=1; both hold until Flush or reset.
REQ-030 SHALL, on Flush=1, take priority over all requests in that cycle: pointers to 0, both error flags to 0, RData to 0 when Fwft=0; WInc/RInc in that cycle are ignored and do not set error flags.
REQ-031 SHALL produce a read-data sequence identical to the accepted-write sequence across any number of pointer wrap-arounds.

Reset
REQ-032 SHALL, on Rst=0 at any time, immediately clear wptr, rptr, OverflowErr, UnderflowErr and RData (Fwft=0) to 0, giving REmpty=1, WFull=0, Count=0, AlmostEmpty=1 (when AEmptyThr >= 0), AlmostFull=0 (when AFullThr > 0).
REQ-033 SHALL not reset the storage array; contents become unreachable through the cleared pointers.
REQ-034 SHALL abandon any in-flight read or write on mid-operation reset; the first accepted write after reset release is the first word read.

Verification (DataWidth=8, Depth=4, AFullThr=3, AEmptyThr=1)
REQ-035 Fill: Fwft=0, write 0x11,0x22,0x33,0x44 -> Count 1..4, AlmostFull at Count=3, WFull at 4; 5th write 0x55 -> rejected, OverflowErr=1, Count stays 4.
REQ-036 Drain: from full, four reads -> RData 0x11,0x22,0x33,0x44, each one cycle after its RInc; REmpty=1 after the 4th; extra read -> UnderflowErr=1, RData stays 0x44.
REQ-037 Simultaneous: full + WInc=RInc=1 -> Count 3, write dropped; empty + WInc=RInc=1 -> Count 1, RData unchanged.
REQ-038 Wrap: 10 streaming writes 0x00..0x09 with reads interleaved at Count=2 -> read order 0x00..0x09, no error flags.
REQ-039 Fwft=1: write 0xA5 into empty -> next cycle REmpty=0, RData=0xA5 with no RInc; RInc -> REmpty=1.
REQ-040 Flush/reset: Count=3 with OverflowErr=1, assert Flush with WInc=1 -> Count 0, flags 0, write ignored; mid-stream Rst=0 -> outputs at reset values asynchronously, before the next Clk edge.
